// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: funct3 codes, FSM states,
// access-size encoding and the lane/legality helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_WB       = 3'd3,
    ST_ERR      = 3'd4
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  function automatic logic [7:0] lane_mask(input mem_size_e size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // funct3[1:0] is the access size for every legal load and store code.
  function automatic logic op_legal(input logic is_store, input logic [2:0] funct3,
                                    input logic [2:0] off);
    logic f3_ok;
    logic al_ok;
    f3_ok = is_store ? (funct3[2] == 1'b0) : (funct3 != 3'b111);
    case (mem_size_e'(funct3[1:0]))
      SZ_B:    al_ok = 1'b1;
      SZ_H:    al_ok = (off[0] == 1'b0);
      SZ_W:    al_ok = (off[1:0] == 2'b00);
      default: al_ok = (off == 3'b000);
    endcase
    return f3_ok && al_ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed field from a load doubleword and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);

  logic [63:0] w_field;

  assign w_field = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_field;
    case (i_funct3)
      F3_B:    o_data = {{56{w_field[7]}}, w_field[7:0]};
      F3_H:    o_data = {{48{w_field[15]}}, w_field[15:0]};
      F3_W:    o_data = {{32{w_field[31]}}, w_field[31:0]};
      F3_BU:   o_data = {56'd0, w_field[7:0]};
      F3_HU:   o_data = {48'd0, w_field[15:0]};
      F3_WU:   o_data = {32'd0, w_field[31:0]};
      default: o_data = w_field;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV64 load/store stage: one op at a time through a valid/ready doubleword
// memory port, with load results written back to the register file.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err,
  output logic              busy,
  output mem_state_e        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with stable payload until that edge.

  mem_state_e        r_state;
  logic [2:0]        r_funct3;
  logic [2:0]        r_off;
  logic [4:0]        r_rd;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [7:0]        r_mem_wmask;
  logic              r_wb_we;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_err;

  logic              w_accept;
  logic [2:0]        w_off;
  logic              w_legal;
  mem_size_e         w_size;
  logic [XLEN-1:0]   w_load_data;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_off     = req_addr[2:0];
  assign w_size    = mem_size_e'(req_funct3[1:0]);
  assign w_legal   = op_legal(req_is_store, req_funct3, w_off);

  load_align u_load_align (
    .i_rdata  (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_funct3        <= '0;
      r_off           <= '0;
      r_rd            <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_wb_we         <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_data       <= '0;
      r_err           <= 1'b0;
    end else begin
      r_wb_we <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3    <= req_funct3;
            r_off       <= w_off;
            r_rd        <= req_rd;
            r_mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
            r_mem_we    <= req_is_store;
            r_mem_wdata <= req_wdata << {w_off, 3'b000};
            r_mem_wmask <= lane_mask(w_size, w_off);
            if (w_legal) begin
              r_state         <= ST_REQ;
              r_mem_req_valid <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= r_mem_we ? ST_IDLE : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_wb_data <= w_load_data;
            r_wb_rd   <= r_rd;
            r_wb_we   <= (r_rd != 5'd0);
            r_state   <= ST_WB;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;
  assign wb_we         = r_wb_we;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign err           = r_err;
  assign busy          = (r_state != ST_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver pushes expected memory requests,
// write-backs and error pulses; a negedge monitor pops and compares them.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        err;
  logic        busy;
  mem_state_e  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [136:0] exp_mem_q[$];  // {we, addr, wdata, mask}
  logic [68:0]  exp_wb_q[$];   // {rd, data}
  logic [63:0]  exp_err_q[$];  // offending address
  logic [63:0]  rdata_q[$];

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .err           (err),
    .busy          (busy),
    .o_dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: got unexpected event want none", name);
  endtask

  // memory responder: zero-wait read data the cycle after a load handshake
  initial begin
    logic hs;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      hs = !rst && mem_req_valid && mem_req_ready && !mem_we;
      @(posedge clk);
      if (hs) begin
        #1;
        if (rdata_q.size() == 0) unexpected("rsp_no_data");
        else mem_rdata = rdata_q.pop_front();
        mem_rsp_valid = 1'b1;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [136:0] e;
    logic [68:0]  w;
    logic [63:0]  a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_mem_q.size() == 0) unexpected("mem_req");
          else begin
            e = exp_mem_q.pop_front();
            chk("mem_we", mem_we, e[136]);
            chk("mem_addr", mem_addr, e[135:72]);
            if (e[136]) begin
              chk("mem_wdata", mem_wdata, e[71:8]);
              chk("mem_wmask", mem_wmask, e[7:0]);
            end
          end
        end
        if (wb_we) begin
          if (exp_wb_q.size() == 0) unexpected("wb_we");
          else begin
            w = exp_wb_q.pop_front();
            chk("wb_rd", wb_rd, w[68:64]);
            chk("wb_data", wb_data, w[63:0]);
          end
        end
        if (err) begin
          if (exp_err_q.size() == 0) unexpected("err");
          else begin
            a = exp_err_q.pop_front();
            chk("err_no_mem", mem_req_valid, 1'b0);
          end
        end
      end
    end
  end

  // driver: issue one op, push its expectations, check the cycle it frees up
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                       input logic exp_err, input logic [63:0] exp_wdata, input logic [7:0] exp_mask,
                       input logic [63:0] exp_wb, input string name);
    int lat;
    int exp_lat;
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_ready"}, req_ready, 1'b1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    if (exp_err) exp_err_q.push_back(addr);
    else begin
      exp_mem_q.push_back({st, addr & ~64'h7, exp_wdata, exp_mask});
      if (!st) begin
        rdata_q.push_back(rdata);
        if (rd != 5'd0) exp_wb_q.push_back({rd, exp_wb});
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_lat = (exp_err || st) ? 2 : 4;
    for (lat = 1; lat < 50; lat++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_is_store  = 1'b0;
    req_funct3    = '0;
    req_addr      = '0;
    req_wdata     = '0;
    req_rd        = '0;
    mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_wb", {wb_we, wb_rd, wb_data}, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_out", {mem_addr, mem_we, mem_wdata, mem_wmask}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1'b1);

    // stores
    do_op(1, 3'b011, 64'h1000, 64'h1122334455667788, 0, 0, 0, 64'h1122334455667788, 8'hFF, 0, "sd");
    do_op(1, 3'b000, 64'h1003, 64'h00000000000000AB, 0, 0, 0, 64'h00000000AB000000, 8'h08, 0, "sb");
    do_op(1, 3'b001, 64'h1006, 64'h000000000000BEEF, 0, 0, 0, 64'hBEEF000000000000, 8'hC0, 0, "sh");
    do_op(1, 3'b010, 64'h100C, 64'h00000000DEADBEEF, 0, 0, 0, 64'hDEADBEEF00000000, 8'hF0, 0, "sw");

    // loads
    do_op(0, 3'b000, 64'h2005, 0, 5, 64'h0000800000000000, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, "lb");
    do_op(0, 3'b100, 64'h2005, 0, 5, 64'h0000800000000000, 0, 0, 0, 64'h0000000000000080, "lbu");
    do_op(0, 3'b010, 64'h2004, 0, 6, 64'h8000000100000000, 0, 0, 0, 64'hFFFFFFFF80000001, "lw");
    do_op(0, 3'b110, 64'h2004, 0, 6, 64'h8000000100000000, 0, 0, 0, 64'h0000000080000001, "lwu");
    do_op(0, 3'b001, 64'h2002, 0, 7, 64'h000000007FFE0000, 0, 0, 0, 64'h0000000000007FFE, "lh_pos");
    do_op(0, 3'b001, 64'h2000, 0, 9, 64'h0000000000008001, 0, 0, 0, 64'hFFFFFFFFFFFF8001, "lh_neg");
    do_op(0, 3'b101, 64'h2006, 0, 8, 64'h9234000000000000, 0, 0, 0, 64'h0000000000009234, "lhu");
    do_op(0, 3'b011, 64'h2008, 0, 31, 64'hCAFEF00DDEADBEEF, 0, 0, 0, 64'hCAFEF00DDEADBEEF, "ld");

    // illegal ops
    do_op(0, 3'b001, 64'h2001, 0, 4, 0, 1, 0, 0, 0, "lh_misaligned");
    do_op(0, 3'b111, 64'h2000, 0, 4, 0, 1, 0, 0, 0, "load_f3_111");
    do_op(1, 3'b011, 64'h1004, 64'h1, 0, 0, 1, 0, 0, 0, "sd_misaligned");
    do_op(1, 3'b100, 64'h1000, 64'h1, 0, 0, 1, 0, 0, 0, "store_f3_100");
    do_op(0, 3'b010, 64'h2002, 0, 4, 0, 1, 0, 0, 0, "lw_misaligned");

    // load to x0: memory access but no write-back
    do_op(0, 3'b011, 64'h3000, 0, 0, 64'h0000000000000123, 0, 0, 0, 0, "ld_x0");

    // stalled memory, then reset mid-request
    mem_req_ready = 1'b0;
    req_valid     = 1'b1;
    req_is_store  = 1'b0;
    req_funct3    = 3'b011;
    req_addr      = 64'h3008;
    req_rd        = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1'b1);
      chk("stall_addr", mem_addr, 64'h3008);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", mem_req_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_state", dbg_state, ST_IDLE);

    do_op(1, 3'b011, 64'h4000, 64'h0000000000000055, 0, 0, 0, 64'h0000000000000055, 8'hFF, 0, "sd_after_rst");

    repeat (4) @(negedge clk);
    chk("left_mem", exp_mem_q.size(), 0);
    chk("left_wb", exp_wb_q.size(), 0);
    chk("left_err", exp_err_q.size(), 0);
    chk("left_rdata", rdata_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
